// File: rtl/i2c_slave_seq.sv
// I2C slave bus-phase sequencer: synchronises SCL/SDA, detects START/STOP/edges, drives the phase code.
// Latency: state changes on the 3rd clk edge after a pin transition. No backpressure; it only observes the pins.
// Optional SCL stall abort is compiled in with I2C_SEQ_TIMEOUT_EN.
module i2c_slave_seq #(
    parameter logic [6:0]  ID             = 7'd2,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SCL,
    input  logic       SDA,
    output logic [2:0] state,
    output logic [2:0] bit_cnt,
    output logic       scl_rise,
    output logic       scl_fall,
    output logic       rw,
    output logic       addr_match,
    output logic       byte_done,
    output logic       nack
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_ADDR  = 3'd2,
        S_RW    = 3'd3,
        S_ACK   = 3'd4,
        S_MEM   = 3'd5,
        S_DATA  = 3'd6,
        S_STOP  = 3'd7
    } phase_t;

    // Which byte the current ACK slot belongs to.
    typedef enum logic [1:0] {
        K_ADDR = 2'd0,
        K_MEM  = 2'd1,
        K_WR   = 2'd2,
        K_RD   = 2'd3
    } ack_kind_t;

    logic      scl_m, scl_s, scl_d;
    logic      sda_m, sda_s, sda_d;
    logic      start_ev, stop_ev, timeout;
    phase_t    phase;
    ack_kind_t ack_kind;
    logic [6:0] addr_sr;
    logic      byte_full;

    // Sync flops reset high so an idle bus produces no spurious edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_m <= 1'b1;
            scl_s <= 1'b1;
            scl_d <= 1'b1;
            sda_m <= 1'b1;
            sda_s <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_m <= SCL;
            scl_s <= scl_m;
            scl_d <= scl_s;
            sda_m <= SDA;
            sda_s <= sda_m;
            sda_d <= sda_s;
        end
    end

    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;
    assign start_ev = sda_d & ~sda_s & scl_s;
    assign stop_ev  = ~sda_d & sda_s & scl_s;
    assign state    = phase;

`ifdef I2C_SEQ_TIMEOUT_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= 16'd0;
        end else if (phase == S_IDLE || scl_rise || scl_fall || start_ev) begin
            stall_cnt <= 16'd0;
        end else if (stall_cnt != TIMEOUT_CYCLES) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign timeout = (stall_cnt == TIMEOUT_CYCLES);
`else
    // No stall abort: the parameter only matters when the counter is built.
    assign timeout = 1'b0 & (TIMEOUT_CYCLES != 16'd0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase      <= S_IDLE;
            bit_cnt    <= 3'd0;
            rw         <= 1'b0;
            addr_match <= 1'b0;
            byte_done  <= 1'b0;
            nack       <= 1'b0;
            addr_sr    <= 7'd0;
            byte_full  <= 1'b0;
            ack_kind   <= K_ADDR;
        end else begin
            byte_done <= 1'b0;
            if (start_ev) begin
                phase     <= S_START;
                bit_cnt   <= 3'd0;
                rw        <= 1'b0;
                nack      <= 1'b0;
                addr_sr   <= 7'd0;
                byte_full <= 1'b0;
            end else if (stop_ev && phase != S_IDLE) begin
                phase     <= S_STOP;
                bit_cnt   <= 3'd0;
                byte_full <= 1'b0;
            end else if (timeout) begin
                phase     <= S_IDLE;
                bit_cnt   <= 3'd0;
                nack      <= 1'b0;
                byte_full <= 1'b0;
            end else begin
                case (phase)
                    S_IDLE: ;
                    S_STOP: phase <= S_IDLE;
                    S_START: begin
                        if (scl_fall) begin
                            phase   <= S_ADDR;
                            bit_cnt <= 3'd0;
                        end
                    end
                    S_ADDR: begin
                        if (scl_rise) begin
                            addr_sr <= {addr_sr[5:0], sda_s};
                            bit_cnt <= bit_cnt + 3'd1;
                        end else if (scl_fall && bit_cnt == 3'd7) begin
                            phase <= S_RW;
                        end
                    end
                    S_RW: begin
                        if (scl_rise) begin
                            rw         <= sda_s;
                            addr_match <= (addr_sr == ID);
                        end else if (scl_fall) begin
                            if (addr_match) begin
                                phase    <= S_ACK;
                                bit_cnt  <= 3'd0;
                                ack_kind <= K_ADDR;
                            end else begin
                                phase <= S_IDLE;
                            end
                        end
                    end
                    S_ACK: begin
                        // Only the master's ACK after read data is sampled.
                        if (scl_rise) begin
                            if (ack_kind == K_RD && sda_s) nack <= 1'b1;
                        end else if (scl_fall) begin
                            bit_cnt <= 3'd0;
                            case (ack_kind)
                                K_ADDR:  phase <= rw ? S_DATA : S_MEM;
                                K_RD:    phase <= nack ? S_IDLE : S_DATA;
                                default: phase <= S_DATA;
                            endcase
                        end
                    end
                    S_MEM, S_DATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                byte_done <= 1'b1;
                                byte_full <= 1'b1;
                            end
                        end else if (scl_fall && byte_full) begin
                            phase     <= S_ACK;
                            bit_cnt   <= 3'd0;
                            byte_full <= 1'b0;
                            if (phase == S_MEM)
                                ack_kind <= K_MEM;
                            else
                                ack_kind <= rw ? K_RD : K_WR;
                        end
                    end
                    default: phase <= S_IDLE;
                endcase
            end
        end
    end

endmodule
